// File: rtl/image_generator.sv
// Raster RGB test-pattern source feeding the processing core's input FIFO; also publishes the stream geometry.
// Latency: the first pixel is offered in the first cycle after reset; afterwards one pixel per clock.
// Backpressure: fifo_full stalls writes in the same cycle with zero latency, and the counters hold.
module image_generator #(
    parameter int DWIDTH     = 24,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int NUM_FRAME  = 1,
    parameter int MEDIA_TYPE = 0
) (
    input  logic              clock,
    input  logic              reset,
    output logic [10:0]       width,
    output logic [10:0]       height,
    output logic [10:0]       num_frame,
    output logic              media_type,
    input  logic              fifo_full,
    output logic [DWIDTH-1:0] fifo_data,
    output logic              fifo_wrreq
);

    localparam logic [0:0] GEN  = 1'b0;
    localparam logic [0:0] DONE = 1'b1;

    // An empty stream never leaves DONE, so the wrapped "last" values below are never used.
    localparam bit          EMPTY  = (IMG_WIDTH == 0) || (IMG_HEIGHT == 0) || (NUM_FRAME == 0);
    localparam logic [10:0] X_LAST = 11'(IMG_WIDTH - 1);
    localparam logic [10:0] Y_LAST = 11'(IMG_HEIGHT - 1);
    localparam logic [10:0] F_LAST = 11'(NUM_FRAME - 1);

    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] f;
    logic [0:0]  state;

    assign width      = 11'(IMG_WIDTH);
    assign height     = 11'(IMG_HEIGHT);
    assign num_frame  = 11'(NUM_FRAME);
    assign media_type = 1'(MEDIA_TYPE);

    // Gating with reset keeps the strobe quiet during the reset cycle itself, before state has been cleared.
    assign fifo_wrreq = !reset && (state == GEN) && !fifo_full;

    always_comb begin
        fifo_data = '0;
        if (!reset) begin
            fifo_data[23:16] = x[7:0];
            fifo_data[15:8]  = y[7:0];
            fifo_data[7:0]   = f[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x     <= '0;
            y     <= '0;
            f     <= '0;
            state <= EMPTY ? DONE : GEN;
        end else if (fifo_wrreq) begin
            if (x < X_LAST) begin
                x <= x + 11'd1;
            end else begin
                x <= '0;
                if (y < Y_LAST) begin
                    y <= y + 11'd1;
                end else begin
                    y <= '0;
                    if (f < F_LAST) begin
                        f <= f + 11'd1;
                    end else begin
                        // The final pixel keeps its counter values; only the state changes.
                        x     <= x;
                        y     <= y;
                        state <= DONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_image_generator.sv
// Bench for image_generator: raster queue model, stall/reset sequences, and randomized back-pressure.
module tb_image_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a  = 1'b1;
    logic rst_b  = 1'b1;
    logic full_m = 1'b0;
    logic full_b = 1'b0;

    logic [10:0] m_width, m_height, m_nf;
    logic        m_mt, m_wr;
    logic [23:0] m_data;
    logic [10:0] d_width, d_height, d_nf;
    logic        d_mt, d_wr;
    logic [23:0] d_data;
    logic [10:0] g_width, g_height, g_nf;
    logic        g_mt, g_wr;
    logic [23:0] g_data;
    logic [10:0] b_width, b_height, b_nf;
    logic        b_mt, b_wr;
    logic [31:0] b_data;

    image_generator #(.DWIDTH(24), .IMG_WIDTH(4), .IMG_HEIGHT(3), .NUM_FRAME(2), .MEDIA_TYPE(0)) u_main (
        .clock(clk), .reset(rst_a), .width(m_width), .height(m_height), .num_frame(m_nf),
        .media_type(m_mt), .fifo_full(full_m), .fifo_data(m_data), .fifo_wrreq(m_wr));

    image_generator #(.DWIDTH(24), .IMG_WIDTH(4), .IMG_HEIGHT(0), .NUM_FRAME(2), .MEDIA_TYPE(0)) u_deg (
        .clock(clk), .reset(rst_a), .width(d_width), .height(d_height), .num_frame(d_nf),
        .media_type(d_mt), .fifo_full(full_m), .fifo_data(d_data), .fifo_wrreq(d_wr));

    image_generator #(.DWIDTH(24), .IMG_WIDTH(1920), .IMG_HEIGHT(1080), .NUM_FRAME(3), .MEDIA_TYPE(1)) u_geo (
        .clock(clk), .reset(rst_a), .width(g_width), .height(g_height), .num_frame(g_nf),
        .media_type(g_mt), .fifo_full(full_m), .fifo_data(g_data), .fifo_wrreq(g_wr));

    image_generator #(.DWIDTH(32), .IMG_WIDTH(300), .IMG_HEIGHT(5), .NUM_FRAME(2), .MEDIA_TYPE(0)) u_big (
        .clock(clk), .reset(rst_b), .width(b_width), .height(b_height), .num_frame(b_nf),
        .media_type(b_mt), .fifo_full(full_b), .fifo_data(b_data), .fifo_wrreq(b_wr));

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    int deg_writes = 0;
    always @(negedge clk) if (d_wr === 1'b1) deg_writes++;

    typedef struct {
        int          idx;
        logic [23:0] word;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected stream: every frame, every line, every column, colours are the low byte of each index.
    task automatic build_model(input int w, input int h, input int n);
        exp_q.delete();
        for (int fr = 0; fr < n; fr++)
            for (int ln = 0; ln < h; ln++)
                for (int col = 0; col < w; col++)
                    exp_q.push_back(32'(((col % 256) << 16) + ((ln % 256) << 8) + (fr % 256)));
    endtask

    task automatic do_reset();
        rst_a = 1'b1;
        @(negedge clk);
        check("reset_wrreq", {63'd0, m_wr}, 64'd0);
        check("reset_data", {40'd0, m_data}, 64'd0);
        @(posedge clk);
        #1 rst_a = 1'b0;
    endtask

    // Runs the main DUT for a number of cycles with fifo_full high in [stall_lo, stall_hi).
    task automatic capture(input int cycles, input int stall_lo, input int stall_hi, input int total);
        int written;
        logic exp_wr;
        written = 0;
        got_q.delete();
        for (int c = 0; c < cycles; c++) begin
            full_m = (c >= stall_lo) && (c < stall_hi);
            @(negedge clk);
            exp_wr = !full_m && (written < total);
            check($sformatf("wrreq_cycle%0d", c), {63'd0, m_wr}, {63'd0, exp_wr});
            if (full_m && written < exp_q.size())
                check($sformatf("stall_hold_cycle%0d", c), {40'd0, m_data}, {40'd0, exp_q[written][23:0]});
            if (m_wr === 1'b1) begin
                got_q.push_back({8'd0, m_data});
                written++;
            end
            @(posedge clk);
            #1;
        end
        full_m = 1'b0;
    endtask

    task automatic compare_got(input string name);
        check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_word%0d", name, i), {32'd0, got_q[i]}, {32'd0, exp_q[i]});
    endtask

    initial begin
        int budget;
        int tail_writes;
        logic [31:0] w;

        vecs[0] = '{0,  24'h000000};
        vecs[1] = '{3,  24'h030000};
        vecs[2] = '{4,  24'h000100};
        vecs[3] = '{12, 24'h000001};
        vecs[4] = '{23, 24'h030201};

        @(posedge clk);
        #1;
        check("geo_width_rst",  {53'd0, g_width},  64'd1920);
        check("geo_height_rst", {53'd0, g_height}, 64'd1080);
        check("geo_nf_rst",     {53'd0, g_nf},     64'd3);
        check("geo_mt_rst",     {63'd0, g_mt},     64'd1);
        check("main_width_rst", {53'd0, m_width},  64'd4);

        // Small stream with no back-pressure.
        build_model(4, 3, 2);
        do_reset();
        capture(30, 0, 0, 24);
        compare_got("stream");
        for (int i = 0; i < 5; i++)
            if (vecs[i].idx < got_q.size())
                check($sformatf("table_word%0d", vecs[i].idx), {32'd0, got_q[vecs[i].idx]}, {40'd0, vecs[i].word});

        // Five-cycle stall starting at word 5.
        do_reset();
        capture(36, 5, 10, 24);
        compare_got("stall");

        // Reset after ten writes restarts the whole sequence from pixel (0,0) of frame 0.
        do_reset();
        capture(10, 0, 0, 24);
        check("pre_abort_count", 64'(got_q.size()), 64'd10);
        do_reset();
        capture(28, 0, 0, 24);
        compare_got("restart");

        check("geo_width_run",  {53'd0, g_width},  64'd1920);
        check("geo_height_run", {53'd0, g_height}, 64'd1080);
        check("geo_nf_run",     {53'd0, g_nf},     64'd3);
        check("geo_mt_run",     {63'd0, g_mt},     64'd1);

        check("deg_writes", 64'(deg_writes), 64'd0);
        check("deg_height", {53'd0, d_height}, 64'd0);
        check("deg_width",  {53'd0, d_width},  64'd4);

        // Randomized back-pressure on a wider stream whose column count passes 255.
        build_model(300, 5, 2);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst_b = 1'b0;
        budget = 0;
        while (exp_q.size() > 0 && budget < 20000) begin
            full_b = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rand_wrreq", {63'd0, b_wr}, {63'd0, !full_b});
            if (b_wr === 1'b1) begin
                w = exp_q.pop_front();
                check("rand_word", {32'd0, b_data}, {32'd0, w});
            end
            @(posedge clk);
            #1;
            budget++;
        end
        check("rand_all_written", 64'(exp_q.size()), 64'd0);

        tail_writes = 0;
        for (int c = 0; c < 20; c++) begin
            full_b = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (b_wr !== 1'b0) tail_writes++;
            @(posedge clk);
            #1;
        end
        check("done_sticky", 64'(tail_writes), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
